// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, state enum and ctrl decode for the bit-serial ALU
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    localparam logic [1:0] SLICE_AND  = 2'd0;
    localparam logic [1:0] SLICE_OR   = 2'd1;
    localparam logic [1:0] SLICE_ADD  = 2'd2;
    localparam logic [1:0] SLICE_LESS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic [1:0] op;
    } slice_ctrl_t;

    function automatic logic ctrl_legal(input logic [3:0] c);
        return c inside {CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR};
    endfunction

    function automatic slice_ctrl_t decode_ctrl(input logic [3:0] c);
        slice_ctrl_t s;
        s = '{a_inv: 1'b0, b_inv: 1'b0, op: SLICE_AND};
        case (c)
            CTRL_OR:  s.op = SLICE_OR;
            CTRL_ADD: s.op = SLICE_ADD;
            CTRL_SUB, CTRL_SLT: begin
                s.b_inv = 1'b1;
                s.op    = SLICE_ADD;
            end
            CTRL_NOR: begin
                s.a_inv = 1'b1;
                s.b_inv = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// rtl/alu_serial_ctrl_if.sv - request/response handshake bundle of the bit-serial ALU
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;
    logic             err_o;

    modport master (
        output in_valid, src1_i, src2_i, ctrl_i, out_ready,
        input  in_ready, out_valid, result_o, zero_o, cout_o, overflow_o, err_o
    );

    modport slave (
        input  in_valid, src1_i, src2_i, ctrl_i, out_ready,
        output in_ready, out_valid, result_o, zero_o, cout_o, overflow_o, err_o
    );
endinterface

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - one-bit ALU slice with operand inversion, full adder and less input
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       less,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       result,
    output logic       cout
);
    logic aa, bb, sum;

    assign aa   = a ^ a_invert;
    assign bb   = b ^ b_invert;
    assign sum  = aa ^ bb ^ cin;
    assign cout = (aa & bb) | (cin & (aa ^ bb));

    always_comb begin
        result = 1'b0;
        case (op)
            SLICE_AND:  result = aa & bb;
            SLICE_OR:   result = aa | bb;
            SLICE_ADD:  result = sum;
            SLICE_LESS: result = less;
            default:    result = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - sequences one ALU slice LSB-first over WIDTH cycles with SLT fix-up and flags
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_serial_ctrl_if.slave bus
);
    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [3:0]       ctrl_q;
    logic [CW-1:0]    cnt;
    logic             carry, cout_q, ovf_q, set_q, err_q;
    slice_ctrl_t      sc;
    logic             slice_res, slice_cout, last_bit, msb_ovf;

    assign sc       = decode_ctrl(ctrl_q);
    assign last_bit = (cnt == LAST);
    assign msb_ovf  = carry ^ slice_cout;

    alu_bit_slice u_slice (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .less     (1'b0),
        .a_invert (sc.a_inv),
        .b_invert (sc.b_inv),
        .cin      (carry),
        .op       (sc.op),
        .result   (slice_res),
        .cout     (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Illegal codes pass through FIX so the error response lands one edge after acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nxt = ctrl_legal(bus.ctrl_i) ? ST_RUN : ST_FIX;
            ST_RUN:  if (last_bit) state_nxt = (ctrl_q == CTRL_SLT) ? ST_FIX : ST_DONE;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            ctrl_q <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            set_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    a_sh   <= bus.src1_i;
                    b_sh   <= bus.src2_i;
                    ctrl_q <= bus.ctrl_i;
                    cnt    <= '0;
                    carry  <= (bus.ctrl_i == CTRL_SUB) || (bus.ctrl_i == CTRL_SLT);
                    res    <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    set_q  <= 1'b0;
                    err_q  <= !ctrl_legal(bus.ctrl_i);
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= {slice_res, res[WIDTH-1:1]};
                    carry <= slice_cout;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        set_q <= slice_res ^ msb_ovf;
                        if (ctrl_q inside {CTRL_ADD, CTRL_SUB, CTRL_SLT}) cout_q <= slice_cout;
                        if (ctrl_q inside {CTRL_ADD, CTRL_SUB})           ovf_q  <= msb_ovf;
                    end
                end
                ST_FIX: res <= {{(WIDTH-1){1'b0}}, set_q};
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.out_valid  = (state == ST_DONE);
    assign bus.result_o   = res;
    assign bus.zero_o     = (state == ST_DONE) && (res == '0);
    assign bus.cout_o     = cout_q;
    assign bus.overflow_o = ovf_q;
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - randomized and directed bench for alu_serial_ctrl against an arithmetic model
module tb_alu_serial_ctrl;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         cout;
        logic         ovf;
        logic         err;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t got;
    exp_t m;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        exp_t       e;
        logic [W:0] s;
        e = '{res: '0, zero: 1'b0, cout: 1'b0, ovf: 1'b0, err: 1'b0, lat: W};
        s = {1'b0, a} + {1'b0, ~b} + 1;
        case (c)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0010: begin
                s      = {1'b0, a} + {1'b0, b};
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b0110: begin
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b0111: begin
                e.res  = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                e.cout = s[W];
                e.lat  = W + 1;
            end
            default: begin
                e.err = 1'b1;
                e.lat = 1;
            end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Every cycle the result is presented it must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                mon_e = exp_q[0];
                check("result", {32'd0, bus.result_o}, {32'd0, mon_e.res});
                check("zero", {63'd0, bus.zero_o}, {63'd0, mon_e.zero});
                check("cout", {63'd0, bus.cout_o}, {63'd0, mon_e.cout});
                check("overflow", {63'd0, bus.overflow_o}, {63'd0, mon_e.ovf});
                check("err", {63'd0, bus.err_o}, {63'd0, mon_e.err});
                check("in_ready_in_done", {63'd0, bus.in_ready}, 64'd0);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    task automatic scramble_inputs();
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.src1_i    = $urandom;
        bus.src2_i    = $urandom;
        bus.ctrl_i    = 4'($urandom);
        bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                          input int hold, output exp_t res_seen);
        exp_t e;
        int   lat;
        int   n;
        e        = model(a, b, c);
        res_seen = '{res: '0, zero: 1'b0, cout: 1'b0, ovf: 1'b0, err: 1'b0, lat: 0};
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid  = 1'b1;
        bus.src1_i    = a;
        bus.src2_i    = b;
        bus.ctrl_i    = c;
        bus.out_ready = 1'b0;
        @(posedge clk);
        exp_q.push_back(e);
        #1 scramble_inputs();
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            scramble_inputs();
        end
        check("latency", 64'(lat), 64'(e.lat));
        if (lat == 0) begin
            exp_q.delete();
            return;
        end
        bus.out_ready = 1'b0;
        res_seen = '{res: bus.result_o, zero: bus.zero_o, cout: bus.cout_o,
                     ovf: bus.overflow_o, err: bus.err_o, lat: lat};
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.src1_i   = $urandom;
            bus.src2_i   = $urandom;
            bus.ctrl_i   = 4'($urandom);
            @(posedge clk);
            #1;
            check("out_valid_held", {63'd0, bus.out_valid}, 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("in_ready_after_handshake", {63'd0, bus.in_ready}, 64'd1);
        check("out_valid_after_handshake", {63'd0, bus.out_valid}, 64'd0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return {1'b1, {(W-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] legal [6];
        logic [3:0] c;
        legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        bus.in_valid  = 1'b0;
        bus.src1_i    = '0;
        bus.src2_i    = '0;
        bus.ctrl_i    = '0;
        bus.out_ready = 1'b0;

        m = model(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
        check("model_add_res", {32'd0, m.res}, 64'h8000_0000);
        check("model_add_ovf", {63'd0, m.ovf}, 64'd1);
        m = model(32'd5, 32'd5, 4'b0110);
        check("model_sub_cout", {63'd0, m.cout}, 64'd1);
        m = model(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111);
        check("model_slt_res", {32'd0, m.res}, 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_result", {32'd0, bus.result_o}, 64'd0);
        check("rst_flags", {60'd0, bus.zero_o, bus.cout_o, bus.overflow_o, bus.err_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 0, got);
        check("add_res", {32'd0, got.res}, 64'h8000_0000);
        check("add_flags", {60'd0, got.zero, got.cout, got.ovf, got.err}, 64'b0010);
        check("add_lat", 64'(got.lat), 64'd32);
        run_op(32'd5, 32'd5, 4'b0110, 1, got);
        check("sub_flags", {60'd0, got.zero, got.cout, got.ovf, got.err}, 64'b1100);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 0, got);
        check("slt_res", {32'd0, got.res}, 64'd1);
        check("slt_ovf", {63'd0, got.ovf}, 64'd0);
        check("slt_lat", 64'(got.lat), 64'd33);
        run_op(32'h0, 32'h0, 4'b1100, 0, got);
        check("nor_res", {32'd0, got.res}, 64'hFFFF_FFFF);
        check("nor_flags", {62'd0, got.cout, got.ovf}, 64'd0);
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 5, got);
        check("and_res", {32'd0, got.res}, 64'hF000_F000);
        check("and_flags", {62'd0, got.cout, got.ovf}, 64'd0);

        run_op(32'h1234_5678, 32'h0, 4'b1111, 0, got);
        check("illegal_err", {63'd0, got.err}, 64'd1);
        check("illegal_res", {32'd0, got.res}, 64'd0);
        check("illegal_zero", {63'd0, got.zero}, 64'd1);
        check("illegal_lat", 64'(got.lat), 64'd1);
        run_op(32'd1, 32'd2, 4'b0010, 0, got);
        check("err_cleared", {63'd0, got.err}, 64'd0);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.src1_i   = 32'h1234_5678;
        bus.src2_i   = 32'h1111_1111;
        bus.ctrl_i   = 4'b0010;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_result", {32'd0, bus.result_o}, 64'd0);
        check("midrst_flags", {60'd0, bus.zero_o, bus.cout_o, bus.overflow_o, bus.err_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_result", {63'd0, bus.out_valid}, 64'd0);
        run_op(32'd3, 32'd4, 4'b0010, 0, got);
        check("after_rst_add", {32'd0, got.res}, 64'd7);

        for (int i = 0; i < 150; i++) begin
            c = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal[$urandom_range(0, 5)];
            run_op(pick_operand(), pick_operand(), c, $urandom_range(0, 3), got);
        end

        repeat (2) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
